mem_bus_arbiter: RTL

- Shares one single-port synchronous memory between two requesters: the Cpu core (port 0) and a DMA/loader/debug master (port 1).
- Both requesters use the Cpu bus style: req_rdwr, which_rdwr, addr and data_out in; data_in and a one-cycle ack out.
- Arbitrates round-robin, latches the winning request, drives the memory, and waits out a fixed read latency before acknowledging.
- Sits between the Cpu core and the top-level RAM.

---
 rtl/mem_bus_arbiter_if.sv | 55 +++++
 rtl/mem_bus_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter: two Cpu-style requester ports, the
// single-port memory side, and arbiter status.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  enable;

    logic                  cpu_req_rdwr;
    logic                  cpu_which_rdwr;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_data_out;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_data_in;

    logic                  dma_req_rdwr;
    logic                  dma_which_rdwr;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_data_out;
    logic                  dma_ack;
    logic [DATA_WIDTH-1:0] dma_data_in;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;
    logic                  grant;

    // Arbiter side
    modport slave (
        input  enable,
        input  cpu_req_rdwr, cpu_which_rdwr, cpu_addr, cpu_data_out,
        output cpu_ack, cpu_data_in,
        input  dma_req_rdwr, dma_which_rdwr, dma_addr, dma_data_out,
        output dma_ack, dma_data_in,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, grant
    );

    // Environment side: requesters plus the memory
    modport master (
        output enable,
        output cpu_req_rdwr, cpu_which_rdwr, cpu_addr, cpu_data_out,
        input  cpu_ack, cpu_data_in,
        output dma_req_rdwr, dma_which_rdwr, dma_addr, dma_data_out,
        input  dma_ack, dma_data_in,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, grant
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between
// the Cpu core (port 0) and a DMA/loader/debug master (port 1). The winning
// request is latched, presented to memory for one cycle, and acknowledged
// after the fixed read latency (reads) or immediately (writes).
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_t                state_q, state_d;
    logic                  last_q, last_d;
    logic                  grant_q, grant_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  capture;
    logic                  win;
    logic                  access;

    // Per-port request fields gathered into arrays indexed by port ID
    logic [1:0]            req_vec;
    logic [1:0]            which_vec;
    logic [ADDR_WIDTH-1:0] addr_arr  [2];
    logic [DATA_WIDTH-1:0] wdata_arr [2];

    assign req_vec      = {bus.dma_req_rdwr,   bus.cpu_req_rdwr};
    assign which_vec    = {bus.dma_which_rdwr, bus.cpu_which_rdwr};
    assign addr_arr[0]  = bus.cpu_addr;
    assign addr_arr[1]  = bus.dma_addr;
    assign wdata_arr[0] = bus.cpu_data_out;
    assign wdata_arr[1] = bus.dma_data_out;

    // State and latched-transaction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;   // port 0 wins the first tie
            grant_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: grant in IDLE, one memory strobe, count out read latency, ack
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        win     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.enable && (req_vec != 2'b00)) begin
                    // On a tie the port that did not win last time goes next
                    win     = (req_vec == 2'b11) ? ~last_q : req_vec[1];
                    grant_d = win;
                    last_d  = win;
                    we_d    = which_vec[win];
                    addr_d  = addr_arr[win];
                    wdata_d = wdata_arr[win];
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = ACK;
                end else begin
                    cnt_d   = LAT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Counter keeps running regardless of enable so memory timing holds
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    capture = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One read-data holding register per port; only that port's read capture updates it
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_WIDTH-1:0] din_q, din_d;

        // Select new read data only on this port's capture cycle
        always_comb begin
            din_d = din_q;
            if (capture && (grant_q == 1'(gi))) begin
                din_d = bus.mem_rdata;
            end
        end

        // Read-data register
        always_ff @(posedge clk) begin
            if (rst) begin
                din_q <= '0;
            end else begin
                din_q <= din_d;
            end
        end
    end

    // Memory side is driven only during the single ACCESS cycle
    assign access        = (state_q == ACCESS);
    assign bus.mem_en    = access;
    assign bus.mem_we    = access & we_q;
    assign bus.mem_addr  = access ? addr_q  : '0;
    assign bus.mem_wdata = access ? wdata_q : '0;

    assign bus.cpu_ack     = (state_q == ACK) && (grant_q == 1'b0);
    assign bus.dma_ack     = (state_q == ACK) && (grant_q == 1'b1);
    assign bus.cpu_data_in = g_port[0].din_q;
    assign bus.dma_data_in = g_port[1].din_q;

    assign bus.busy  = (state_q != IDLE);
    assign bus.grant = grant_q;
endmodule
